rxclk_phase_align: RTL

RXCLK_PHASE_ALIGN -- requirements
Module: rxclk_phase_align

---
 rtl/surf_align_pkg.sv | 16 +
 rtl/phase_window_tracker.sv | 41 ++++
 rtl/rxclk_phase_align.sv | 137 +++++++++++++
 3 files changed

// File: rtl/surf_align_pkg.sv
// surf_align_pkg: shared step width and alignment FSM state encoding
package surf_align_pkg;
  localparam int PS_STEP_W = 10;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_SHIFT,
    ST_WAIT_DONE,
    ST_CENTER_SHIFT,
    ST_CENTER_WAIT,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;
endpackage

// File: rtl/phase_window_tracker.sv
// phase_window_tracker: tracks the current passing run and keeps the earliest longest one
module phase_window_tracker
  import surf_align_pkg::*;
(
  input  logic                 aclk_i,
  input  logic                 aclk_rst_i,
  input  logic                 clr_i,
  input  logic                 upd_i,
  input  logic                 pass_i,
  input  logic [PS_STEP_W-1:0] step_i,
  output logic [PS_STEP_W-1:0] best_start_o,
  output logic [PS_STEP_W-1:0] best_len_o
);
  logic [PS_STEP_W-1:0] r_run_start, r_run_len, r_best_start, r_best_len;
  logic [PS_STEP_W-1:0] w_len, w_start;
  assign w_len   = pass_i ? r_run_len + PS_STEP_W'(1) : '0;
  assign w_start = (pass_i && r_run_len == '0) ? step_i : r_run_start;
  assign best_start_o = r_best_start;
  assign best_len_o   = r_best_len;
  // strict compare keeps the earliest window on a tie
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (clr_i) begin
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (upd_i) begin
      r_run_start <= w_start;
      r_run_len   <= w_len;
      if (w_len > r_best_len) begin
        r_best_start <= w_start;
        r_best_len   <= w_len;
      end
    end
  end
endmodule

// File: rtl/rxclk_phase_align.sv
// rxclk_phase_align: scans MMCM phase steps for capture errors, then centers in the widest clean window
module rxclk_phase_align
  import surf_align_pkg::*;
#(
  parameter int NUM_STEPS     = 448,
  parameter int MEAS_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 64,
  parameter int PS_TIMEOUT    = 256
) (
  input  logic                 aclk_i,
  input  logic                 aclk_rst_i,
  input  logic                 start_i,
  input  logic                 capture_err_i,
  output logic                 ps_en_o,
  output logic                 ps_incdec_o,
  input  logic                 ps_done_i,
  output logic                 busy_o,
  output logic                 locked_o,
  output logic                 fail_o,
  output logic [PS_STEP_W-1:0] win_start_o,
  output logic [PS_STEP_W-1:0] win_len_o,
  output logic [15:0]          err_count_o
);
  localparam int CNT_A   = MEAS_CYCLES > SETTLE_CYCLES ? MEAS_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX = CNT_A > PS_TIMEOUT ? CNT_A : PS_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  align_state_t         r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [PS_STEP_W-1:0] r_step, r_center, r_win_start, r_win_len;
  logic                 r_meas_err, r_pass;
  logic [15:0]          r_err_count;
  logic                 w_rest, w_start_ok, w_timeout;
  logic [PS_STEP_W-1:0] w_best_start, w_best_len, w_target;
  assign w_rest      = r_state inside {ST_IDLE, ST_LOCKED, ST_FAIL};
  assign w_start_ok  = start_i && w_rest;
  assign w_timeout   = r_cnt == CNT_W'(PS_TIMEOUT - 1);
  assign w_target    = w_best_start + (w_best_len >> 1);
  assign ps_en_o     = r_state == ST_SHIFT || r_state == ST_CENTER_SHIFT;
  assign ps_incdec_o = 1'b1;
  assign busy_o      = !w_rest;
  assign locked_o    = r_state == ST_LOCKED;
  assign fail_o      = r_state == ST_FAIL;
  assign win_start_o = r_win_start;
  assign win_len_o   = r_win_len;
  assign err_count_o = r_err_count;
  phase_window_tracker u_tracker (
    .aclk_i       (aclk_i),
    .aclk_rst_i   (aclk_rst_i),
    .clr_i        (w_start_ok),
    .upd_i        (r_state == ST_EVAL),
    .pass_i       (r_pass),
    .step_i       (r_step),
    .best_start_o (w_best_start),
    .best_len_o   (w_best_len)
  );
  // r_cnt is reused: dwell counter in SETTLE/MEASURE, cycles since ps_en_o in the wait states
  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_step      <= '0;
      r_center    <= '0;
      r_win_start <= '0;
      r_win_len   <= '0;
      r_meas_err  <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (r_state == ST_LOCKED && capture_err_i && !(&r_err_count))
        r_err_count <= r_err_count + 16'd1;
      case (r_state)
        ST_IDLE, ST_LOCKED, ST_FAIL: begin
          if (start_i) begin
            r_state     <= ST_SETTLE;
            r_cnt       <= '0;
            r_step      <= '0;
            r_win_start <= '0;
            r_win_len   <= '0;
            r_err_count <= '0;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state    <= ST_MEASURE;
            r_cnt      <= '0;
            r_meas_err <= 1'b0;
          end
        end
        ST_MEASURE: begin
          r_cnt      <= r_cnt + CNT_W'(1);
          r_meas_err <= r_meas_err | capture_err_i;
          if (r_cnt == CNT_W'(MEAS_CYCLES - 1)) begin
            r_state <= ST_EVAL;
            r_cnt   <= '0;
            r_pass  <= !(r_meas_err | capture_err_i);
          end
        end
        ST_EVAL: r_state <= ST_SHIFT;
        ST_SHIFT, ST_CENTER_SHIFT: begin
          r_state <= r_state == ST_SHIFT ? ST_WAIT_DONE : ST_CENTER_WAIT;
          r_cnt   <= CNT_W'(1);
        end
        ST_WAIT_DONE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (ps_done_i) begin
            r_cnt <= '0;
            if (r_step == PS_STEP_W'(NUM_STEPS - 1)) begin
              r_step      <= '0;
              r_win_start <= w_best_start;
              r_win_len   <= w_best_len;
              r_center    <= w_target;
              r_state     <= w_best_len == '0 ? ST_FAIL :
                             w_target == '0   ? ST_LOCKED : ST_CENTER_SHIFT;
            end else begin
              r_step  <= r_step + PS_STEP_W'(1);
              r_state <= ST_SETTLE;
            end
          end else if (w_timeout) begin
            r_state <= ST_FAIL;
          end
        end
        ST_CENTER_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (ps_done_i) begin
            r_cnt    <= '0;
            r_center <= r_center - PS_STEP_W'(1);
            r_state  <= r_center == PS_STEP_W'(1) ? ST_LOCKED : ST_CENTER_SHIFT;
          end else if (w_timeout) begin
            r_state <= ST_FAIL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
